// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: handshake FSM states, widths, helpers.
package mem_stage_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } memState_t;

    // A load/store whose byte offset is non-zero cannot be issued as a word access.
    function automatic logic isMisaligned(input logic memOp, input logic [1:0] byteOff);
        return memOp && (byteOff != 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_dmem_handshake.sv
// Data-memory req/ack handshake: FSM, wait counter, request drive, stall and error flags.
module dmem_handshake
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              dmem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              stall,
    output logic              addrErr,
    output logic              busErr
);

    localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

    memState_t          state, nextState;
    logic [CNT_W-1:0]   waitCnt, nextCnt;
    logic               memOp;
    logic               misaligned;
    logic               timeout;

    assign memOp      = memRead | memWrite;
    assign misaligned = isMisaligned(memOp, addr[1:0]);
    assign timeout    = (state == ST_WAIT) && !dmem_ack && (waitCnt == CNT_W'(WAIT_LIMIT - 1));

    // The EX/MEM register holds while stalled, so address/data stay stable in WAIT.
    assign dmem_we    = dmem_req & memWrite;
    assign dmem_addr  = {addr[ADDR_W-1:2], 2'b00};
    assign dmem_wdata = wdata;

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextCnt;
        end
    end

    // Next state, request and stall/error flags.
    always_comb begin
        nextState = state;
        nextCnt   = waitCnt;
        dmem_req  = 1'b0;
        stall     = 1'b0;
        addrErr   = 1'b0;
        busErr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (misaligned) begin
                    addrErr = 1'b1;
                end else if (memOp) begin
                    dmem_req = 1'b1;
                    if (!dmem_ack) begin
                        stall     = 1'b1;
                        nextState = ST_WAIT;
                        nextCnt   = '0;
                    end
                end
            end
            ST_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    nextState = ST_IDLE;
                    nextCnt   = '0;
                end else if (timeout) begin
                    busErr    = 1'b1;
                    nextState = ST_IDLE;
                    nextCnt   = '0;
                end else begin
                    stall   = 1'b1;
                    nextCnt = waitCnt + 1'b1;
                end
            end
            default: begin
                nextState = ST_IDLE;
                nextCnt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// EX/MEM register, data-memory access and MEM/WB register with write-back mux.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite_ex,
    input  logic                  MemRead_ex,
    input  logic                  MemWrite_ex,
    input  logic                  MemtoReg_ex,
    input  logic [DATA_W-1:0]     ALUResult_ex,
    input  logic [DATA_W-1:0]     MemWriteData_ex,
    input  logic [REG_ADDR_W-1:0] RegWriteAddr_ex,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    output logic [DATA_W-1:0]     ALUResult_mem,
    output logic [REG_ADDR_W-1:0] RegWriteAddr_mem,
    output logic                  RegWrite_mem,
    output logic [DATA_W-1:0]     RegWriteData_wb,
    output logic [REG_ADDR_W-1:0] RegWriteAddr_wb,
    output logic                  RegWrite_wb,
    output logic                  Stall_mem,
    output logic                  AddrErr_mem,
    output logic                  BusErr_mem
);

    logic              MemRead_mem;
    logic              MemWrite_mem;
    logic              MemtoReg_mem;
    logic [DATA_W-1:0] MemWriteData_mem;
    logic              accessErr;

    assign accessErr = AddrErr_mem | BusErr_mem;

    // EX/MEM pipeline register; holds while the memory access stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite_mem     <= 1'b0;
            MemRead_mem      <= 1'b0;
            MemWrite_mem     <= 1'b0;
            MemtoReg_mem     <= 1'b0;
            ALUResult_mem    <= '0;
            MemWriteData_mem <= '0;
            RegWriteAddr_mem <= '0;
        end else if (!Stall_mem) begin
            RegWrite_mem     <= RegWrite_ex;
            MemRead_mem      <= MemRead_ex;
            MemWrite_mem     <= MemWrite_ex;
            MemtoReg_mem     <= MemtoReg_ex;
            ALUResult_mem    <= ALUResult_ex;
            MemWriteData_mem <= MemWriteData_ex;
            RegWriteAddr_mem <= RegWriteAddr_ex;
        end
    end

    dmem_handshake #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .WAIT_LIMIT (WAIT_LIMIT)
    ) uHandshake (
        .clk        (clk),
        .reset      (reset),
        .memRead    (MemRead_mem),
        .memWrite   (MemWrite_mem),
        .addr       (ALUResult_mem[ADDR_W-1:0]),
        .wdata      (MemWriteData_mem),
        .dmem_ack   (dmem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .stall      (Stall_mem),
        .addrErr    (AddrErr_mem),
        .busErr     (BusErr_mem)
    );

    // MEM/WB pipeline register: bubble while stalled, otherwise retire (errors suppress the write).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteData_wb <= '0;
            RegWriteAddr_wb <= '0;
            RegWrite_wb     <= 1'b0;
        end else if (Stall_mem) begin
            RegWrite_wb     <= 1'b0;
        end else begin
            RegWriteData_wb <= MemtoReg_mem ? dmem_rdata : ALUResult_mem;
            RegWriteAddr_wb <= RegWriteAddr_mem;
            RegWrite_wb     <= RegWrite_mem & ~accessErr;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, per-instruction memory responder, scoreboard.
module tb_mem_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned WL = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex;
    logic [DW-1:0] ALUResult_ex, MemWriteData_ex;
    logic [4:0]    RegWriteAddr_ex;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;
    logic          dmem_req, dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] ALUResult_mem;
    logic [4:0]    RegWriteAddr_mem;
    logic          RegWrite_mem;
    logic [DW-1:0] RegWriteData_wb;
    logic [4:0]    RegWriteAddr_wb;
    logic          RegWrite_wb;
    logic          Stall_mem, AddrErr_mem, BusErr_mem;

    always #5 clk = ~clk;

    mem_stage #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .WAIT_LIMIT (WL)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .RegWrite_ex      (RegWrite_ex),
        .MemRead_ex       (MemRead_ex),
        .MemWrite_ex      (MemWrite_ex),
        .MemtoReg_ex      (MemtoReg_ex),
        .ALUResult_ex     (ALUResult_ex),
        .MemWriteData_ex  (MemWriteData_ex),
        .RegWriteAddr_ex  (RegWriteAddr_ex),
        .dmem_rdata       (dmem_rdata),
        .dmem_ack         (dmem_ack),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .ALUResult_mem    (ALUResult_mem),
        .RegWriteAddr_mem (RegWriteAddr_mem),
        .RegWrite_mem     (RegWrite_mem),
        .RegWriteData_wb  (RegWriteData_wb),
        .RegWriteAddr_wb  (RegWriteAddr_wb),
        .RegWrite_wb      (RegWrite_wb),
        .Stall_mem        (Stall_mem),
        .AddrErr_mem      (AddrErr_mem),
        .BusErr_mem       (BusErr_mem)
    );

    // waits: cycle index (0 = first MEM cycle) on which ack is driven; -1 = never.
    typedef struct {
        string         name;
        logic          regWrite, memRead, memWrite, memtoReg;
        logic [31:0]   alu, wdata;
        logic [4:0]    rd;
        int            waits;
        logic [31:0]   rdata;
        int            expStall;
        logic          expReq;
        logic          expAddrErr, expBusErr;
        logic          expWbWrite;
        logic [31:0]   expWbData;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        wr;
    } wb_t;

    vec_t vecs[10];
    wb_t  sbQ[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic driveNop();
        RegWrite_ex     = 1'b0;
        MemRead_ex      = 1'b0;
        MemWrite_ex     = 1'b0;
        MemtoReg_ex     = 1'b0;
        ALUResult_ex    = '0;
        MemWriteData_ex = '0;
        RegWriteAddr_ex = '0;
    endtask

    task automatic runVec(input vec_t v);
        wb_t         e;
        wb_t         got;
        int          cyc;
        int          stallCnt, reqCnt, aErr, bErr;
        logic        stallNow;
        logic [31:0] expAddr;
        expAddr = {v.alu[31:2], 2'b00};
        @(negedge clk);
        RegWrite_ex     = v.regWrite;
        MemRead_ex      = v.memRead;
        MemWrite_ex     = v.memWrite;
        MemtoReg_ex     = v.memtoReg;
        ALUResult_ex    = v.alu;
        MemWriteData_ex = v.wdata;
        RegWriteAddr_ex = v.rd;
        dmem_ack        = 1'b0;
        e.data = v.expWbData;
        e.addr = v.rd;
        e.wr   = v.expWbWrite;
        sbQ.push_back(e);
        @(posedge clk); #1;
        driveNop();
        cyc = 0; stallCnt = 0; reqCnt = 0; aErr = 0; bErr = 0; stallNow = 1'b1;
        while (stallNow && cyc < 40) begin
            dmem_ack   = (v.waits >= 0) && (cyc == v.waits);
            dmem_rdata = v.rdata;
            @(negedge clk);
            if (cyc == 0) begin
                chk({v.name, " RegWrite_mem"}, 32'(RegWrite_mem), 32'(v.regWrite));
                chk({v.name, " ALUResult_mem"}, ALUResult_mem, v.alu);
                chk({v.name, " RegWriteAddr_mem"}, 32'(RegWriteAddr_mem), 32'(v.rd));
            end else begin
                chk({v.name, " bubble RegWrite_wb"}, 32'(RegWrite_wb), 32'(0));
            end
            if (dmem_req) begin
                reqCnt++;
                chk({v.name, " dmem_addr"}, dmem_addr, expAddr);
                chk({v.name, " dmem_we"}, 32'(dmem_we), 32'(v.memWrite));
                if (v.memWrite) chk({v.name, " dmem_wdata"}, dmem_wdata, v.wdata);
            end
            stallCnt += int'(Stall_mem);
            aErr     += int'(AddrErr_mem);
            bErr     += int'(BusErr_mem);
            stallNow  = Stall_mem;
            @(posedge clk); #1;
            cyc++;
        end
        dmem_ack = 1'b0;
        chk({v.name, " stall never released"}, 32'(stallNow), 32'(0));
        chk({v.name, " stall cycles"}, 32'(stallCnt), 32'(v.expStall));
        chk({v.name, " req cycles"}, 32'(reqCnt), v.expReq ? 32'(v.expStall + 1) : 32'(0));
        chk({v.name, " AddrErr pulses"}, 32'(aErr), 32'(v.expAddrErr));
        chk({v.name, " BusErr pulses"}, 32'(bErr), 32'(v.expBusErr));
        chk({v.name, " req low after retire"}, 32'(dmem_req), 32'(0));
        if (sbQ.size() == 0) begin
            chk({v.name, " scoreboard empty"}, 32'(1), 32'(0));
        end else begin
            got = sbQ.pop_front();
            chk({v.name, " RegWrite_wb"}, 32'(RegWrite_wb), 32'(got.wr));
            chk({v.name, " RegWriteAddr_wb"}, 32'(RegWriteAddr_wb), 32'(got.addr));
            if (got.wr) chk({v.name, " RegWriteData_wb"}, RegWriteData_wb, got.data);
        end
    endtask

    initial begin
        //          name            RW    MR    MW    MtR   alu           wdata         rd  waits rdata         stall req   aErr  bErr  wbW   wbData
        vecs[0] = '{"alu_op",       1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,        5, 0,  32'h0,        0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010};
        vecs[1] = '{"load_0wait",   1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0,        7, 0,  32'hDEAD_BEEF, 0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[2] = '{"store_3wait",  1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0204, 32'hCAFE_F00D, 0, 3,  32'h0,        3,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{"load_misalgn", 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0,        9, 0,  32'h0000_1111, 0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{"load_timeout", 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0,       10, -1, 32'h0,        15, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{"load_2wait",   1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0,        3, 2,  32'h1234_5678, 2,  1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678};
        vecs[6] = '{"alu_r0",       1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,        0, 0,  32'h0,        0,  1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF};
        vecs[7] = '{"store_misalgn",1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0401, 32'h5555_AAAA, 0, 0,  32'h0,        0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[8] = '{"load_ack_last",1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0108, 32'h0,       12, 15, 32'hA5A5_5A5A, 15, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_5A5A};
        vecs[9] = '{"alu_after",    1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0ABC, 32'h0,       31, -1, 32'h0,        0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0ABC};

        reset = 1'b1;
        driveNop();
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset dmem_req", 32'(dmem_req), 32'(0));
        chk("reset Stall_mem", 32'(Stall_mem), 32'(0));
        chk("reset RegWrite_mem", 32'(RegWrite_mem), 32'(0));
        chk("reset RegWrite_wb", 32'(RegWrite_wb), 32'(0));
        chk("reset RegWriteData_wb", RegWriteData_wb, 32'(0));
        chk("reset ALUResult_mem", ALUResult_mem, 32'(0));
        reset = 1'b0;

        for (int i = 0; i < 9; i++) runVec(vecs[i]);

        // Reset asserted while the handshake sits in WAIT.
        @(negedge clk);
        MemWrite_ex     = 1'b1;
        ALUResult_ex    = 32'h0000_0500;
        MemWriteData_ex = 32'h0000_0077;
        @(posedge clk); #1;
        driveNop();
        @(negedge clk);
        chk("rst_wait req before", 32'(dmem_req), 32'(1));
        chk("rst_wait stall before", 32'(Stall_mem), 32'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_wait stall in WAIT", 32'(Stall_mem), 32'(1));
        #1 reset = 1'b1;
        #1;
        chk("rst_wait req dropped", 32'(dmem_req), 32'(0));
        chk("rst_wait stall dropped", 32'(Stall_mem), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        runVec(vecs[9]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound in case a wait never resolves.
    initial begin
        #200000;
        $display("FAIL global timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

endmodule
